// File: rtl/passcode_checker.sv
// Multi-digit passcode verifier: collects NUM_DIGITS digits after a user ID is found,
// grants access on a full match, blinks on failure and locks out after repeated failures.
module passcode_checker #(
    parameter int DIGIT_W        = 4,
    parameter int NUM_DIGITS     = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 1024,
    parameter int BLINK_CYCLES   = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                userIDfoundFlag,
    input  logic                                loadButton_s,
    input  logic [DIGIT_W-1:0]                  passInput,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]       PASSWORD,
    input  logic                                logout,
    output logic                                accessFlag,
    output logic                                blinkFlag,
    output logic                                outOfAttemptsFlag,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attemptsLeft,
    output logic [$clog2(NUM_DIGITS+1)-1:0]     digitIndex
);

    localparam int PW_W  = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS + 1);
    localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
    localparam int BLK_W = $clog2(BLINK_CYCLES + 1);
    // A permanent lockout never counts, so its counter collapses to a single idle bit.
    localparam int LCK_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(NUM_DIGITS - 1);
    localparam logic [ATT_W-1:0] MAX_ATT        = ATT_W'(MAX_ATTEMPTS);
    localparam logic [BLK_W-1:0] BLK_LAST       = BLK_W'(BLINK_CYCLES - 1);
    localparam logic [LCK_W-1:0] LCK_LAST       = LCK_W'((LOCKOUT_CYCLES > 0) ? (LOCKOUT_CYCLES - 1) : 0);
    localparam logic             LOCK_PERMANENT = (LOCKOUT_CYCLES == 0);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ENTRY      = 3'd1,
        ST_VERIFY     = 3'd2,
        ST_GRANTED    = 3'd3,
        ST_FAIL_BLINK = 3'd4,
        ST_LOCKED     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] digit_q, digit_d;
    logic             mismatch_q, mismatch_d;
    logic [ATT_W-1:0] fail_q, fail_d, fail_inc_s;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             access_q, access_d;
    logic             blink_q, blink_d;
    logic             locked_q, locked_d;
    logic [ATT_W-1:0] attempts_q, attempts_d;

    // Digit k of the stored password; digit 0 sits in the most significant field.
    function automatic logic [DIGIT_W-1:0] digit_at(input logic [PW_W-1:0] pw,
                                                    input logic [IDX_W-1:0] k);
        logic [PW_W-1:0] shifted;
        shifted = pw >> (DIGIT_W * (NUM_DIGITS - 1 - int'(k)));
        return shifted[DIGIT_W-1:0];
    endfunction

    assign fail_inc_s = (fail_q == MAX_ATT) ? MAX_ATT : (fail_q + ATT_W'(1));

    // Next-state and datapath update logic.
    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        mismatch_d  = mismatch_q;
        fail_d      = fail_q;
        blink_cnt_d = blink_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        case (state_q)
            ST_IDLE: begin
                digit_d    = '0;
                mismatch_d = 1'b0;
                if (userIDfoundFlag) begin
                    state_d = ST_ENTRY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                // Losing the user ID discards the attempt, even on a press cycle.
                if (!userIDfoundFlag) begin
                    state_d    = ST_IDLE;
                    digit_d    = '0;
                    mismatch_d = 1'b0;
                end else if (loadButton_s) begin
                    if (passInput != digit_at(PASSWORD, digit_q)) begin
                        mismatch_d = 1'b1;
                    end else begin
                        mismatch_d = mismatch_q;
                    end
                    digit_d = digit_q + IDX_W'(1);
                    if (digit_q == LAST_IDX) begin
                        state_d = ST_VERIFY;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end else begin
                    state_d = ST_ENTRY;
                end
            end
            ST_VERIFY: begin
                blink_cnt_d = '0;
                lock_cnt_d  = '0;
                if (!mismatch_q) begin
                    fail_d  = '0;
                    state_d = ST_GRANTED;
                end else begin
                    fail_d = fail_inc_s;
                    if (fail_inc_s == MAX_ATT) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_FAIL_BLINK;
                    end
                end
            end
            ST_GRANTED: begin
                if (logout || !userIDfoundFlag) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GRANTED;
                end
            end
            ST_FAIL_BLINK: begin
                if (blink_cnt_q == BLK_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLK_W'(1);
                    state_d     = ST_FAIL_BLINK;
                end
            end
            ST_LOCKED: begin
                if (lock_cnt_q == LCK_LAST) begin
                    if (!LOCK_PERMANENT) begin
                        fail_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    lock_cnt_d = lock_cnt_q + LCK_W'(1);
                    state_d    = ST_LOCKED;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                digit_d    = '0;
                mismatch_d = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so every flag is a registered Moore output.
    always_comb begin
        access_d   = (state_d == ST_GRANTED);
        blink_d    = (state_d == ST_FAIL_BLINK);
        locked_d   = (state_d == ST_LOCKED);
        attempts_d = MAX_ATT - fail_d;
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            digit_q     <= '0;
            mismatch_q  <= 1'b0;
            fail_q      <= '0;
            blink_cnt_q <= '0;
            lock_cnt_q  <= '0;
            access_q    <= 1'b0;
            blink_q     <= 1'b0;
            locked_q    <= 1'b0;
            attempts_q  <= MAX_ATT;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            mismatch_q  <= mismatch_d;
            fail_q      <= fail_d;
            blink_cnt_q <= blink_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            access_q    <= access_d;
            blink_q     <= blink_d;
            locked_q    <= locked_d;
            attempts_q  <= attempts_d;
        end
    end

    assign accessFlag        = access_q;
    assign blinkFlag         = blink_q;
    assign outOfAttemptsFlag = locked_q;
    assign attemptsLeft      = attempts_q;
    assign digitIndex        = digit_q;

endmodule

// File: tb/tb_passcode_checker.sv
// Scoreboard bench for passcode_checker: default, permanent-lockout and 6x6 single-attempt
// instances, with expected attempt outcomes queued at entry and popped at the result edge.
module tb_passcode_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        uid, load, logout;
    logic [3:0]  pin;
    logic [15:0] pw;
    logic        acc_a, blk_a, loc_a;
    logic [1:0]  att_a;
    logic [2:0]  idx_a;
    logic        acc_b, blk_b, loc_b;
    logic [1:0]  att_b;
    logic [2:0]  idx_b;
    logic        uid_c, load_c, logout_c;
    logic [5:0]  pin_c;
    logic [35:0] pw_c;
    logic        acc_c, blk_c, loc_c;
    logic [0:0]  att_c;
    logic [2:0]  idx_c;

    passcode_checker u_a (
        .clk(clk), .rst(rst), .userIDfoundFlag(uid), .loadButton_s(load), .passInput(pin),
        .PASSWORD(pw), .logout(logout), .accessFlag(acc_a), .blinkFlag(blk_a),
        .outOfAttemptsFlag(loc_a), .attemptsLeft(att_a), .digitIndex(idx_a)
    );

    passcode_checker #(.LOCKOUT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .userIDfoundFlag(uid), .loadButton_s(load), .passInput(pin),
        .PASSWORD(pw), .logout(logout), .accessFlag(acc_b), .blinkFlag(blk_b),
        .outOfAttemptsFlag(loc_b), .attemptsLeft(att_b), .digitIndex(idx_b)
    );

    passcode_checker #(.DIGIT_W(6), .NUM_DIGITS(6), .MAX_ATTEMPTS(1)) u_c (
        .clk(clk), .rst(rst), .userIDfoundFlag(uid_c), .loadButton_s(load_c), .passInput(pin_c),
        .PASSWORD(pw_c), .logout(logout_c), .accessFlag(acc_c), .blinkFlag(blk_c),
        .outOfAttemptsFlag(loc_c), .attemptsLeft(att_c), .digitIndex(idx_c)
    );

    typedef struct packed {
        logic       acc;
        logic       blk;
        logic       loc;
        logic [1:0] att;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   fail_ab  = 0;
    int   fail_c   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 4-digit entry on consecutive cycles into the shared A/B inputs.
    task automatic attempt_ab(input logic [15:0] code);
        exp_t e;
        exp_t got;
        if (code == pw) begin
            fail_ab = 0;
        end else begin
            fail_ab = fail_ab + 1;
        end
        e.acc = (code == pw);
        e.blk = (code != pw) && (fail_ab < 3);
        e.loc = (code != pw) && (fail_ab >= 3);
        e.att = 2'(3 - fail_ab);
        sb.push_back(e);
        tick();
        for (int k = 0; k < 4; k++) begin
            load = 1'b1;
            pin  = code[15-4*k -: 4];
            tick();
        end
        load = 1'b0;
        checks++;
        if (idx_a !== 3'd4 || acc_a !== 1'b0 || blk_a !== 1'b0 || loc_a !== 1'b0) begin
            failures++;
            $display("FAIL verify_cycle: got idx=%0d acc=%b blk=%b loc=%b, expected idx=4 acc=0 blk=0 loc=0",
                     idx_a, acc_a, blk_a, loc_a);
        end
        tick();
        got = sb.pop_front();
        checks++;
        if ({acc_a, blk_a, loc_a, att_a} !== got) begin
            failures++;
            $display("FAIL attempt_a code=%h: got acc/blk/loc/att=%b, expected %b",
                     code, {acc_a, blk_a, loc_a, att_a}, got);
        end
        checks++;
        if ({acc_b, blk_b, loc_b, att_b} !== got) begin
            failures++;
            $display("FAIL attempt_b code=%h: got acc/blk/loc/att=%b, expected %b",
                     code, {acc_b, blk_b, loc_b, att_b}, got);
        end
    endtask

    // Full 6-digit entry into the 6x6 single-attempt instance.
    task automatic attempt_c(input logic [35:0] code);
        exp_t e;
        exp_t got;
        if (code == pw_c) begin
            fail_c = 0;
        end else begin
            fail_c = fail_c + 1;
        end
        e.acc = (code == pw_c);
        e.blk = 1'b0;
        e.loc = (code != pw_c);
        e.att = 2'(1 - fail_c);
        sb.push_back(e);
        tick();
        for (int k = 0; k < 6; k++) begin
            load_c = 1'b1;
            pin_c  = code[35-6*k -: 6];
            tick();
        end
        load_c = 1'b0;
        checks++;
        if (idx_c !== 3'd6) begin
            failures++;
            $display("FAIL sweep_index: got %0d expected 6", idx_c);
        end
        tick();
        got = sb.pop_front();
        checks++;
        if ({acc_c, blk_c, loc_c, 1'b0, att_c} !== got) begin
            failures++;
            $display("FAIL attempt_c code=%h: got acc/blk/loc/att=%b, expected %b",
                     code, {acc_c, blk_c, loc_c, 1'b0, att_c}, got);
        end
    endtask

    task automatic do_logout();
        logout = 1'b1;
        tick();
        logout = 1'b0;
        checks++;
        if (acc_a !== 1'b0) begin
            failures++;
            $display("FAIL logout_access: got %b expected 0", acc_a);
        end
    endtask

    task automatic count_blink(input string name);
        int n = 0;
        for (int i = 0; i < 100 && blk_a === 1'b1; i++) begin
            n++;
            tick();
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL %s: blink high %0d cycles, expected 8", name, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({acc_a, blk_a, loc_a, att_a, idx_a} !== {3'b000, 2'd3, 3'd0}) begin
            failures++;
            $display("FAIL reset_a: got %b expected %b", {acc_a, blk_a, loc_a, att_a, idx_a}, {3'b000, 2'd3, 3'd0});
        end
        checks++;
        if ({acc_c, blk_c, loc_c, att_c, idx_c} !== {3'b000, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL reset_c: got %b expected %b", {acc_c, blk_c, loc_c, att_c, idx_c}, {3'b000, 1'b1, 3'd0});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_correct_entry();
        uid  = 1'b1;
        load = 1'b1;
        pin  = 4'hA;
        tick();
        load = 1'b0;
        checks++;
        if (idx_a !== 3'd0) begin
            failures++;
            $display("FAIL press_on_uid_rise: got idx %0d expected 0", idx_a);
        end
        attempt_ab(16'hA5C3);
        do_logout();
        tick();
        checks++;
        if (idx_a !== 3'd0) begin
            failures++;
            $display("FAIL idle_clears_index: got %0d expected 0", idx_a);
        end
    endtask

    task automatic test_wrong_digit();
        attempt_ab(16'hA5C4);
        count_blink("blink_len_1");
        attempt_ab(16'hA5C3);
        do_logout();
    endtask

    task automatic test_entry_abort();
        attempt_ab(16'h1234);
        count_blink("blink_len_2");
        tick();
        for (int k = 0; k < 2; k++) begin
            load = 1'b1;
            pin  = (k == 0) ? 4'hA : 4'h5;
            tick();
        end
        load = 1'b0;
        checks++;
        if (idx_a !== 3'd2) begin
            failures++;
            $display("FAIL abort_partial_index: got %0d expected 2", idx_a);
        end
        uid  = 1'b0;
        load = 1'b1;
        pin  = 4'hC;
        tick();
        load = 1'b0;
        checks++;
        if (idx_a !== 3'd0 || att_a !== 2'd2 || acc_a !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: got idx=%0d att=%0d acc=%b expected idx=0 att=2 acc=0", idx_a, att_a, acc_a);
        end
        uid = 1'b1;
        attempt_ab(16'hA5C3);
        do_logout();
    endtask

    task automatic test_lockout();
        int n = 0;
        attempt_ab(16'h0000);
        count_blink("blink_len_3");
        attempt_ab(16'hFFFF);
        count_blink("blink_len_4");
        attempt_ab(16'hA5C2);
        for (int i = 0; i < 3000 && loc_a === 1'b1; i++) begin
            n++;
            if (i == 10) begin
                checks++;
                if (idx_a !== 3'd4) begin
                    failures++;
                    $display("FAIL lockout_ignores_press: got idx %0d expected 4", idx_a);
                end
            end
            load = (i < 10);
            pin  = 4'hA;
            tick();
        end
        load = 1'b0;
        checks++;
        if (n != 1024) begin
            failures++;
            $display("FAIL lockout_len: got %0d cycles expected 1024", n);
        end
        checks++;
        if (loc_a !== 1'b0 || att_a !== 2'd3) begin
            failures++;
            $display("FAIL lockout_exit: got loc=%b att=%0d expected loc=0 att=3", loc_a, att_a);
        end
        checks++;
        if (loc_b !== 1'b1) begin
            failures++;
            $display("FAIL permanent_at_1024: got %b expected 1", loc_b);
        end
    endtask

    task automatic test_permanent_lockout();
        int n = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (loc_b === 1'b1) n++;
        end
        checks++;
        if (n != 5000) begin
            failures++;
            $display("FAIL permanent_len: locked %0d of 5000 cycles", n);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({acc_b, blk_b, loc_b, att_b, idx_b} !== {3'b000, 2'd3, 3'd0}) begin
            failures++;
            $display("FAIL async_reset_b: got %b expected %b", {acc_b, blk_b, loc_b, att_b, idx_b}, {3'b000, 2'd3, 3'd0});
        end
        tick();
        rst = 1'b0;
        uid = 1'b0;
        fail_ab = 0;
        tick();
    endtask

    task automatic test_param_sweep();
        uid_c = 1'b1;
        attempt_c(pw_c);
        logout_c = 1'b1;
        tick();
        logout_c = 1'b0;
        checks++;
        if (acc_c !== 1'b0) begin
            failures++;
            $display("FAIL sweep_logout: got %b expected 0", acc_c);
        end
        attempt_c({pw_c[35:6], pw_c[5:0] ^ 6'd1});
    endtask

    initial begin
        rst      = 1'b1;
        uid      = 1'b0;
        load     = 1'b0;
        logout   = 1'b0;
        pin      = 4'h0;
        pw       = 16'hA5C3;
        uid_c    = 1'b0;
        load_c   = 1'b0;
        logout_c = 1'b0;
        pin_c    = 6'd0;
        pw_c     = {6'd12, 6'd63, 6'd0, 6'd33, 6'd7, 6'd45};
        test_reset();
        test_correct_entry();
        test_wrong_digit();
        test_entry_abort();
        test_lockout();
        test_permanent_lockout();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
